mem_arbiter: RTL and testbench

//  Shares one fixed-latency unified memory between the instruction-fetch port and the data-memory port of proc.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arb_lat_cnt.sv | 36 +++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding,
// requester identifiers and the latency-counter load helper.
package mem_arb_pkg;

  // State encoding of the arbiter sequencer.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } state_e;

  // Requester identifiers, also used as the owner / last_grant encoding.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // The counter is loaded in ISSUE; it hits zero in the cycle where
  // mem_rdata becomes valid, hence the minus one.
  function automatic logic [3:0] lat_load(input int unsigned lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between proc's fetch/data ports, the arbiter and the memory.
// slave  : the arbiter's view.
// master : the view of the requesters plus the memory model.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  // data-memory port
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  // memory side
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_done, if_rdata, dm_done, dm_rdata,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_lat_cnt.sv
// 4-bit loadable down-counter with zero flag. Counts memory latency
// while the arbiter waits for read data. Saturates at zero.
module mem_arb_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between instruction fetch and
// data memory. Sequence per grant: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// All outputs are registered. err is sticky until rst.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking
// (otherwise dm always beats if).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          err
);

  // Latency must fit the 4-bit counter and be at least one cycle.
  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_LOAD = lat_load(MEM_LAT);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
`ifdef MEM_ARB_RR_EN
  logic          last_grant_q, last_grant_d;
`endif

  logic winner;
  logic owner_req;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  mem_arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  // Grant selection among the requesters visible in IDLE.
  always_comb begin
    winner = REQ_IF;
`ifdef MEM_ARB_RR_EN
    if (bus.if_req && bus.dm_req) begin
      winner = (last_grant_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else begin
      winner = bus.dm_req ? REQ_DM : REQ_IF;
    end
`else
    winner = bus.dm_req ? REQ_DM : REQ_IF;
`endif
  end

  // Sequencer next-state, latching, capture and error detection.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    owner_req  = (owner_q == REQ_DM) ? bus.dm_req : bus.if_req;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          // Latch everything now so later input changes are ignored.
          owner_d  = winner;
          wr_d     = (winner == REQ_DM) && bus.dm_wr;
          addr_d   = (winner == REQ_DM) ? bus.dm_addr : bus.if_addr;
          if ((winner == REQ_DM) && bus.dm_wr) begin
            wdata_d = bus.dm_wdata;
          end
          mem_en_d = 1'b1;
          mem_wr_d = (winner == REQ_DM) && bus.dm_wr;
          state_d  = S_ISSUE;
`ifdef MEM_ARB_RR_EN
          last_grant_d = winner;
`endif
        end
      end
      S_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = S_WAIT;
        if (!owner_req) err_d = 1'b1;
      end
      S_WAIT: begin
        if (!owner_req) err_d = 1'b1;
        if (cnt_zero) begin
          // mem_rdata is valid this cycle; writes leave dm_rdata alone.
          if (owner_q == REQ_IF) begin
            if_rdata_d = bus.mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            if (!wr_q) dm_rdata_d = bus.mem_rdata;
            dm_done_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= REQ_IF;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin history; IF after reset so the first tie goes to dm.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with MEM_LAT=2. Table of single
// transactions followed by hand-written multi-cycle sequences.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.MEM_LAT(LAT), .AW(16), .DW(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  // Memory model: data appears exactly LAT cycles after mem_en, garbage otherwise.
  logic [15:0]    mem_model [256];
  logic [LAT-1:0] vpipe = '0;
  logic [15:0]    dpipe [LAT];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) mem_model[bus.mem_addr[7:0]] = bus.mem_wdata;
    for (int i = LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
    dpipe[0] <= mem_model[bus.mem_addr[7:0]];
    vpipe    <= {vpipe[LAT-2:0], bus.mem_en & ~bus.mem_wr};
  end

  assign bus.mem_rdata = vpipe[LAT-1] ? dpipe[LAT-1] : 16'hDEAD;

  typedef struct {
    logic        is_dm;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        pre_en;
    logic [15:0] pre;
    logic [15:0] exp_if;
    logic [15:0] exp_dm;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One isolated transaction starting in the current cycle (cycle 0).
  task automatic run_txn(input vec_t v, input int idx);
    if (v.pre_en) mem_model[v.addr[7:0]] = v.pre;
    if (v.is_dm) begin
      bus.dm_req   = 1'b1;
      bus.dm_wr    = v.wr;
      bus.dm_addr  = v.addr;
      bus.dm_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
      bus.dm_wr   = 1'b0;
    end
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      chk($sformatf("v%0d c%0d mem_en", idx, c), 32'(bus.mem_en), 32'(c == 1));
      if (c == 1) begin
        chk($sformatf("v%0d mem_addr", idx), 32'(bus.mem_addr), 32'(v.addr));
        chk($sformatf("v%0d mem_wr", idx), 32'(bus.mem_wr), 32'(v.wr));
        if (v.wr) chk($sformatf("v%0d mem_wdata", idx), 32'(bus.mem_wdata), 32'(v.wdata));
      end
      chk($sformatf("v%0d c%0d if_done", idx, c), 32'(bus.if_done), 32'((c == LAT + 2) && !v.is_dm));
      chk($sformatf("v%0d c%0d dm_done", idx, c), 32'(bus.dm_done), 32'((c == LAT + 2) && v.is_dm));
      chk($sformatf("v%0d c%0d busy", idx, c), 32'(busy), 32'(c <= LAT + 2));
      if (c == LAT + 2) begin
        chk($sformatf("v%0d if_rdata", idx), 32'(bus.if_rdata), 32'(v.exp_if));
        chk($sformatf("v%0d dm_rdata", idx), 32'(bus.dm_rdata), 32'(v.exp_dm));
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end
    end
    chk($sformatf("v%0d err", idx), 32'(err), 32'd0);
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;

    //         is_dm wr   addr      wdata     pre  pre_val   exp_if    exp_dm
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hABCD, 16'hABCD, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 16'hABCD, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'hABCD, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 16'h0030, 16'hBEEF, 1'b0, 16'h0000, 16'hABCD, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, 16'h5A5A, 16'hBEEF};
    vecs[6] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h0F0F, 16'h5A5A, 16'h0F0F};

    // Reset state
    step();
    step();
    chk("rst mem_en",   32'(bus.mem_en),   32'd0);
    chk("rst mem_wr",   32'(bus.mem_wr),   32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst if_done",  32'(bus.if_done),  32'd0);
    chk("rst dm_done",  32'(bus.dm_done),  32'd0);
    chk("rst if_rdata", 32'(bus.if_rdata), 32'd0);
    chk("rst dm_rdata", 32'(bus.dm_rdata), 32'd0);
    chk("rst busy",     32'(busy),         32'd0);
    chk("rst err",      32'(err),          32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Simultaneous requests: dm first, if granted 5 cycles later.
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.dm_req  = 1'b1;
    bus.dm_wr   = 1'b0;
    bus.dm_addr = 16'h0040;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("tie c%0d dm_done", c), 32'(bus.dm_done), 32'(c == 4));
      chk($sformatf("tie c%0d if_done", c), 32'(bus.if_done), 32'(c == 9));
      if (c == 1) chk("tie mem_addr dm", 32'(bus.mem_addr), 32'h0040);
      if (c == 6) chk("tie mem_addr if", 32'(bus.mem_addr), 32'h0010);
      if (c == 4) begin
        chk("tie dm_rdata", 32'(bus.dm_rdata), 32'h0F0F);
        bus.dm_req = 1'b0;
      end
      if (c == 9) begin
        chk("tie if_rdata", 32'(bus.if_rdata), 32'hABCD);
        bus.if_req = 1'b0;
      end
    end
    chk("tie err", 32'(err), 32'd0);

    // Owner drops req mid-access: sticky err, access still completes.
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("drop c%0d err", c), 32'(err), 32'(c >= 3));
      chk($sformatf("drop c%0d if_done", c), 32'(bus.if_done), 32'(c == 4));
      if (c == 2) bus.if_req = 1'b0;
    end
    chk("drop busy", 32'(busy), 32'd0);
    do_reset();
    chk("drop err cleared", 32'(err), 32'd0);

    // Reset in the middle of a read: no done pulse.
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    step();
    step();
    rst = 1'b1;
    step();
    chk("mrst busy",    32'(busy),         32'd0);
    chk("mrst err",     32'(err),          32'd0);
    chk("mrst if_done", 32'(bus.if_done),  32'd0);
    chk("mrst mem_en",  32'(bus.mem_en),   32'd0);
    rst = 1'b0;
    bus.if_req = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      step();
      chk($sformatf("mrst c%0d if_done", c), 32'(bus.if_done), 32'd0);
      chk($sformatf("mrst c%0d busy", c), 32'(busy), 32'd0);
    end

    // Both requesters held continuously.
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.dm_req  = 1'b1;
    bus.dm_wr   = 1'b0;
    bus.dm_addr = 16'h0040;
    for (int c = 1; c <= 20; c++) begin
      step();
`ifdef MEM_ARB_RR_EN
      chk($sformatf("hold c%0d dm_done", c), 32'(bus.dm_done), 32'((c == 4) || (c == 14)));
      chk($sformatf("hold c%0d if_done", c), 32'(bus.if_done), 32'((c == 9) || (c == 19)));
      if (c == 6) chk("hold mem_addr c6", 32'(bus.mem_addr), 32'h0010);
`else
      chk($sformatf("hold c%0d dm_done", c), 32'(bus.dm_done), 32'((c % 5) == 4));
      chk($sformatf("hold c%0d if_done", c), 32'(bus.if_done), 32'd0);
      if (c == 6) chk("hold mem_addr c6", 32'(bus.mem_addr), 32'h0040);
`endif
      if (c == 1) chk("hold mem_addr c1", 32'(bus.mem_addr), 32'h0040);
      if (c == 20) begin
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end
    end
    step();
    step();
    chk("hold busy", 32'(busy), 32'd0);
    chk("hold err",  32'(err),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
